// File: rtl/bridge_router_pkg.sv
//------------------------------------------------------------------------------
// Module      : bridge_router_pkg
// Description : Shared types and helpers for the bridge address router.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bridge_router_pkg;

    localparam int MAX_LEAVES = 16;
    localparam int LEAF_IDX_W = $clog2(MAX_LEAVES);

    typedef struct packed {
        logic [31:0] from_addr;
        logic [31:0] to_addr;
    } bridge_addr_range_t;

    typedef struct packed {
        logic                  unmapped;
        logic [LEAF_IDX_W-1:0] idx;
    } bridge_router_sel_t;

    localparam bridge_router_sel_t SEL_UNMAPPED = '{unmapped: 1'b1, idx: '0};

    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bridge_range_decode.sv
//------------------------------------------------------------------------------
// Module      : bridge_range_decode
// Description : Priority address-range match; lowest matching index wins.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bridge_range_decode
    import bridge_router_pkg::*;
#(
    parameter int                                     NUM_LEAVES  = 4,
    parameter bridge_addr_range_t [NUM_LEAVES-1:0]    ADDR_RANGES = '0,
    parameter logic [NUM_LEAVES-1:0]                  RELOCATE    = '0
) (
    input  logic [31:0]           addr_i,
    output logic                  hit_o,
    output logic [LEAF_IDX_W-1:0] idx_o,
    output logic [31:0]           addr_o
);

    logic [NUM_LEAVES-1:0] match;

    for (genvar g = 0; g < NUM_LEAVES; g++) begin : g_match
        // Plain unsigned compares: inverted ranges never hit, top-of-space never wraps.
        assign match[g] = (addr_i >= ADDR_RANGES[g].from_addr) &&
                          (addr_i <= ADDR_RANGES[g].to_addr);
    end

    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        addr_o = addr_i;
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o  = 1'b1;
                idx_o  = LEAF_IDX_W'(i);
                addr_o = RELOCATE[i] ? (addr_i - ADDR_RANGES[i].from_addr) : addr_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bridge_router.sv
//------------------------------------------------------------------------------
// Module      : bridge_router
// Description : Routes one APF bridge port to NUM_LEAVES leaves by address;
//               optional miss statistics under BRIDGE_ROUTER_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bridge_router
    import bridge_router_pkg::*;
#(
    parameter int                                  NUM_LEAVES    = 4,
    parameter bridge_addr_range_t [NUM_LEAVES-1:0] ADDR_RANGES   = '0,
    parameter logic [NUM_LEAVES-1:0]               RELOCATE      = '0,
    parameter logic                                ENDIAN_LITTLE = 1'b0,
    parameter logic [31:0]                         UNMAPPED_DATA = 32'hFFFF_FFFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  in_addr,
    input  logic                         in_wr,
    input  logic [31:0]                  in_wr_data,
    input  logic                         in_rd,
    output logic [31:0]                  in_rd_data,
    output logic [NUM_LEAVES-1:0][31:0]  out_addr,
    output logic [NUM_LEAVES-1:0]        out_wr,
    output logic [NUM_LEAVES-1:0][31:0]  out_wr_data,
    output logic [NUM_LEAVES-1:0]        out_rd,
    input  logic [NUM_LEAVES-1:0][31:0]  out_rd_data,
    output logic                         miss_pulse
`ifdef BRIDGE_ROUTER_STATS_EN
    ,
    output logic [15:0]                  miss_count,
    output logic [31:0]                  last_miss_addr
`endif
);

    logic                  dec_hit;
    logic [LEAF_IDX_W-1:0] dec_idx;
    logic [31:0]           dec_addr;
    logic [31:0]           wdata_swapped;

    logic [NUM_LEAVES-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic                        miss_q, miss_d;
    logic [NUM_LEAVES-1:0][31:0] addr_q, addr_d, wdata_q, wdata_d;
    bridge_router_sel_t          sel_q, sel_d;
    logic [31:0]                 rdata_q, rdata_d;

    bridge_range_decode #(
        .NUM_LEAVES  (NUM_LEAVES),
        .ADDR_RANGES (ADDR_RANGES),
        .RELOCATE    (RELOCATE)
    ) u_decode (
        .addr_i (in_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .addr_o (dec_addr)
    );

    assign wdata_swapped = ENDIAN_LITTLE ? byte_swap32(in_wr_data) : in_wr_data;

    always_comb begin
        wr_d    = '0;
        rd_d    = '0;
        miss_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        if (in_wr || in_rd) begin
            miss_d = !dec_hit;
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (dec_hit && (dec_idx == LEAF_IDX_W'(i))) begin
                    addr_d[i]  = dec_addr;
                    wdata_d[i] = wdata_swapped;
                    wr_d[i]    = in_wr;
                    rd_d[i]    = !in_wr;
                end
            end
            // A write on the same cycle swallows the read, so steering stays put.
            if (!in_wr) begin
                sel_d = dec_hit ? '{unmapped: 1'b0, idx: dec_idx} : SEL_UNMAPPED;
            end
        end
    end

    always_comb begin
        rdata_d = UNMAPPED_DATA;
        if (!sel_q.unmapped) begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (sel_q.idx == LEAF_IDX_W'(i)) begin
                    rdata_d = ENDIAN_LITTLE ? byte_swap32(out_rd_data[i]) : out_rd_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            miss_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= SEL_UNMAPPED;
            rdata_q <= UNMAPPED_DATA;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            miss_q  <= miss_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_wr      = wr_q;
    assign out_rd      = rd_q;
    assign out_addr    = addr_q;
    assign out_wr_data = wdata_q;
    assign miss_pulse  = miss_q;
    assign in_rd_data  = rdata_q;

`ifdef BRIDGE_ROUTER_STATS_EN
    logic [15:0] miss_count_q;
    logic [31:0] last_miss_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_count_q     <= '0;
            last_miss_addr_q <= '0;
        end else if (miss_d) begin
            if (miss_count_q != 16'hFFFF) begin
                miss_count_q <= miss_count_q + 16'd1;
            end
            last_miss_addr_q <= in_addr;
        end
    end

    assign miss_count     = miss_count_q;
    assign last_miss_addr = last_miss_addr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bridge_router.sv
//------------------------------------------------------------------------------
// Module      : tb_bridge_router
// Description : Self-checking bench for bridge_router (two configurations).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bridge_router;
    import bridge_router_pkg::*;

    localparam bridge_addr_range_t [1:0] RANGES_A =
        {64'hF800_2000_F800_20FF, 64'hF800_0000_F800_1FFF};
    localparam bridge_addr_range_t [1:0] RANGES_B =
        {64'h0000_0080_0000_017F, 64'h0000_0000_0000_00FF};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_addr = '0;
    logic        in_wr = 1'b0;
    logic [31:0] in_wr_data = '0;
    logic        in_rd = 1'b0;

    logic [31:0]      rd_data_out_a, rd_data_out_b;
    logic [1:0][31:0] addr_a, addr_b, wdata_a, wdata_b;
    logic [1:0][31:0] leaf_rd_a = '0, leaf_rd_b = '0;
    logic [1:0]       wr_a, wr_b, rd_a, rd_b;
    logic             miss_a, miss_b;
`ifdef BRIDGE_ROUTER_STATS_EN
    logic [15:0] mcnt_a, mcnt_b;
    logic [31:0] mlast_a, mlast_b;
`endif

    always #5 clk = ~clk;

    bridge_router #(
        .NUM_LEAVES(2), .ADDR_RANGES(RANGES_A), .RELOCATE(2'b10),
        .ENDIAN_LITTLE(1'b0), .UNMAPPED_DATA(32'hFFFF_FFFF)
    ) dut_a (
        .clk(clk), .reset(reset), .in_addr(in_addr), .in_wr(in_wr),
        .in_wr_data(in_wr_data), .in_rd(in_rd), .in_rd_data(rd_data_out_a),
        .out_addr(addr_a), .out_wr(wr_a), .out_wr_data(wdata_a), .out_rd(rd_a),
        .out_rd_data(leaf_rd_a), .miss_pulse(miss_a)
`ifdef BRIDGE_ROUTER_STATS_EN
        , .miss_count(mcnt_a), .last_miss_addr(mlast_a)
`endif
    );

    bridge_router #(
        .NUM_LEAVES(2), .ADDR_RANGES(RANGES_B), .RELOCATE(2'b00),
        .ENDIAN_LITTLE(1'b1), .UNMAPPED_DATA(32'hFFFF_FFFF)
    ) dut_b (
        .clk(clk), .reset(reset), .in_addr(in_addr), .in_wr(in_wr),
        .in_wr_data(in_wr_data), .in_rd(in_rd), .in_rd_data(rd_data_out_b),
        .out_addr(addr_b), .out_wr(wr_b), .out_wr_data(wdata_b), .out_rd(rd_b),
        .out_rd_data(leaf_rd_b), .miss_pulse(miss_b)
`ifdef BRIDGE_ROUTER_STATS_EN
        , .miss_count(mcnt_b), .last_miss_addr(mlast_b)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic [1:0]  exp_wr;
        logic [1:0]  exp_rd;
        logic        exp_miss;
        int          leaf;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
        in_addr    = a;
        in_wr      = w;
        in_rd      = r;
        in_wr_data = d;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            addr          wr    rd    wdata          ewr    erd    emiss leaf eaddr          ewdata
        vecs.push_back('{32'hF8002010, 1'b1, 1'b0, 32'h1234_5678, 2'b10, 2'b00, 1'b0, 1, 32'h0000_0010, 32'h1234_5678});
        vecs.push_back('{32'hF8000000, 1'b1, 1'b0, 32'hA5A5_A5A5, 2'b01, 2'b00, 1'b0, 0, 32'hF800_0000, 32'hA5A5_A5A5});
        vecs.push_back('{32'hF80020FF, 1'b1, 1'b0, 32'h0000_0001, 2'b10, 2'b00, 1'b0, 1, 32'h0000_00FF, 32'h0000_0001});
        vecs.push_back('{32'hF8002100, 1'b1, 1'b0, 32'hDEAD_BEEF, 2'b00, 2'b00, 1'b1, 1, 32'h0000_00FF, 32'h0000_0001});
        vecs.push_back('{32'hF8001FFF, 1'b0, 1'b1, 32'h0000_0000, 2'b00, 2'b01, 1'b0, 0, 32'hF800_1FFF, 32'h0000_0000});
        vecs.push_back('{32'hF8002004, 1'b1, 1'b1, 32'h0000_0055, 2'b10, 2'b00, 1'b0, 1, 32'h0000_0004, 32'h0000_0055});
        vecs.push_back('{32'h00200000, 1'b0, 1'b1, 32'h0000_0000, 2'b00, 2'b00, 1'b1, -1, 32'h0, 32'h0});
        vecs.push_back('{32'h00000000, 1'b0, 1'b0, 32'h0000_0000, 2'b00, 2'b00, 1'b0, -1, 32'h0, 32'h0});

        // Reset state
        tick();
        tick();
        check("rst_wr_a", 32'(wr_a), 32'h0);
        check("rst_rd_a", 32'(rd_a), 32'h0);
        check("rst_miss_a", 32'(miss_a), 32'h0);
        check("rst_addr_a1", addr_a[1], 32'h0);
        check("rst_wdata_a0", wdata_a[0], 32'h0);
        check("rst_rdata_a", rd_data_out_a, 32'hFFFF_FFFF);
        reset = 1'b0;

        // Table-driven single-cycle accesses on configuration A
        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            exp_q.push_back(vecs[i]);
            tick();
            v = exp_q.pop_front();
            check($sformatf("vec%0d_wr", i), 32'(wr_a), 32'(v.exp_wr));
            check($sformatf("vec%0d_rd", i), 32'(rd_a), 32'(v.exp_rd));
            check($sformatf("vec%0d_miss", i), 32'(miss_a), 32'(v.exp_miss));
            if (v.leaf >= 0) begin
                check($sformatf("vec%0d_addr", i), addr_a[v.leaf], v.exp_addr);
                if (v.wr)
                    check($sformatf("vec%0d_wdata", i), wdata_a[v.leaf], v.exp_wdata);
            end
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0);

        // Read with a three-cycle leaf latency; steering holds afterwards
        leaf_rd_a[0] = 32'h0;
        drive(32'hF8001FFF, 1'b0, 1'b1, 32'h0);
        tick();
        check("rd_strobe_on", 32'(rd_a), 32'h1);
        in_rd = 1'b0;
        tick();
        check("rd_strobe_off", 32'(rd_a), 32'h0);
        tick();
        check("rd_before_leaf", rd_data_out_a, 32'h0);
        leaf_rd_a[0] = 32'hCAFE_F00D;
        tick();
        check("rd_leaf_data", rd_data_out_a, 32'hCAFE_F00D);
        repeat (3) tick();
        check("rd_held", rd_data_out_a, 32'hCAFE_F00D);

        // Unmapped read
        drive(32'h00200000, 1'b0, 1'b1, 32'h0);
        tick();
        check("unm_miss", 32'(miss_a), 32'h1);
        check("unm_no_rd", 32'(rd_a), 32'h0);
        in_rd = 1'b0;
        tick();
        check("unm_miss_gone", 32'(miss_a), 32'h0);
        check("unm_rdata", rd_data_out_a, 32'hFFFF_FFFF);

        // Configuration B: overlap priority, boundaries, byte swapping
        drive(32'h90, 1'b1, 1'b0, 32'hAABB_CCDD);
        tick();
        check("ovl_90_wr", 32'(wr_b), 32'h1);
        check("ovl_90_wdata", wdata_b[0], 32'hDDCC_BBAA);
        check("ovl_90_addr", addr_b[0], 32'h90);
        drive(32'h100, 1'b1, 1'b0, 32'h1);
        tick();
        check("ovl_100_wr", 32'(wr_b), 32'h2);
        check("ovl_100_addr", addr_b[1], 32'h100);
        drive(32'h17F, 1'b1, 1'b0, 32'h1);
        tick();
        check("b_top_wr", 32'(wr_b), 32'h2);
        drive(32'h180, 1'b1, 1'b0, 32'h1);
        tick();
        check("b_past_wr", 32'(wr_b), 32'h0);
        check("b_past_miss", 32'(miss_b), 32'h1);
        leaf_rd_b[1] = 32'h0102_0304;
        drive(32'h100, 1'b0, 1'b1, 32'h0);
        tick();
        check("b_rd_strobe", 32'(rd_b), 32'h2);
        in_rd = 1'b0;
        tick();
        check("b_rd_swap", rd_data_out_b, 32'h0403_0201);

        // Held read, then asynchronous reset mid-operation
        leaf_rd_a[0] = 32'h1212_1212;
        drive(32'hF8001FFF, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("held_rd%0d", k), 32'(rd_a), 32'h1);
        end
        check("held_rdata", rd_data_out_a, 32'h1212_1212);
        reset = 1'b1;
        #1;
        check("arst_rd", 32'(rd_a), 32'h0);
        check("arst_rdata", rd_data_out_a, 32'hFFFF_FFFF);
        in_rd = 1'b0;
        tick();
        reset = 1'b0;
        leaf_rd_a[1] = 32'h0000_0077;
        drive(32'hF8002000, 1'b0, 1'b1, 32'h0);
        tick();
        check("post_rst_rd", 32'(rd_a), 32'h2);
        check("post_rst_addr", addr_a[1], 32'h0);
        in_rd = 1'b0;
        tick();
        check("post_rst_rdata", rd_data_out_a, 32'h0000_0077);

`ifdef BRIDGE_ROUTER_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(32'h00200000, 1'b0, 1'b1, 32'h0);
        tick();
        in_rd = 1'b0;
        tick();
        check("stats_cnt1", 32'(mcnt_a), 32'h1);
        check("stats_last", mlast_a, 32'h0020_0000);
        in_wr = 1'b1;
        repeat (16'hFFFF) tick();
        check("stats_sat", 32'(mcnt_a), 32'hFFFF);
        tick();
        in_wr = 1'b0;
        check("stats_hold", 32'(mcnt_a), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
